// File: rtl/ld_st_wakeup_queue_pkg.sv
// ld_st_wakeup_queue_pkg: shared load/store entry and CDB broadcast types, widths and the tag-match helper
package ld_st_wakeup_queue_pkg;
  localparam int PADDR_WIDTH = 6;
  localparam int PAYLOAD_WIDTH = 32;
  localparam int NUM_CDB_MAX = 4;
  typedef logic [PADDR_WIDTH-1:0] paddr_t;
  typedef struct packed {
    paddr_t                   rs1_paddr;
    paddr_t                   rs2_paddr;
    logic                     rs1_rdy;
    logic                     rs2_rdy;
    logic                     ready;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } ld_st_data_pkt_t;
  typedef struct packed {
    logic   cdb_broadcast;
    paddr_t cdb_p_addr;
  } cdb_pkt_t;
  typedef cdb_pkt_t [NUM_CDB_MAX-1:0] cdb_bus_t;
  function automatic logic cdb_hit(cdb_pkt_t c, paddr_t tag);
    return c.cdb_broadcast && c.cdb_p_addr != '0 && c.cdb_p_addr == tag;
  endfunction
endpackage

// File: rtl/ld_st_wakeup_queue_if.sv
// ld_st_wakeup_queue_if: dispatch/CDB/memory-unit bundle (flush, enq_*, cdb_pkt, deq_*, count); master drives, slave is the queue
interface ld_st_wakeup_queue_if import ld_st_wakeup_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int NUM_CDB = 2
);
  logic                          flush;
  logic                          enq_valid;
  logic                          enq_ready;
  ld_st_data_pkt_t               enq_pkt;
  cdb_pkt_t [NUM_CDB-1:0]        cdb_pkt;
  logic                          deq_valid;
  logic                          deq_ready;
  ld_st_data_pkt_t               deq_pkt;
  logic [$clog2(DEPTH):0]        count;
  modport master (
    output flush, enq_valid, enq_pkt, cdb_pkt, deq_ready,
    input  enq_ready, deq_valid, deq_pkt, count
  );
  modport slave (
    input  flush, enq_valid, enq_pkt, cdb_pkt, deq_ready,
    output enq_ready, deq_valid, deq_pkt, count
  );
endinterface

// File: rtl/ld_st_wakeup_queue_cdb_wakeup_match.sv
// cdb_wakeup_match: entry_in + cdb[NUM_CDB] -> entry_out with rdy bits set by matching broadcasts (x0 always ready) and ready = both rdy
module cdb_wakeup_match import ld_st_wakeup_queue_pkg::*; #(
  parameter int NUM_CDB = 2
) (
  input  ld_st_data_pkt_t        entry_in,
  input  cdb_pkt_t [NUM_CDB-1:0] cdb,
  output ld_st_data_pkt_t        entry_out
);
  logic rs1_rdy_n, rs2_rdy_n;
  always_comb begin
    rs1_rdy_n = entry_in.rs1_rdy || entry_in.rs1_paddr == '0;
    rs2_rdy_n = entry_in.rs2_rdy || entry_in.rs2_paddr == '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      rs1_rdy_n = rs1_rdy_n || cdb_hit(cdb[k], entry_in.rs1_paddr);
      rs2_rdy_n = rs2_rdy_n || cdb_hit(cdb[k], entry_in.rs2_paddr);
    end
    entry_out = entry_in;
    entry_out.rs1_rdy = rs1_rdy_n;
    entry_out.rs2_rdy = rs2_rdy_n;
    entry_out.ready = rs1_rdy_n && rs2_rdy_n;
  end
endmodule

// File: rtl/ld_st_wakeup_queue.sv
// ld_st_wakeup_queue: in-order load/store issue queue with NUM_CDB-port wakeup and enqueue bypass; ports clk, rst, bus (slave: flush/enq/cdb/deq/count)
module ld_st_wakeup_queue import ld_st_wakeup_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int NUM_CDB = 2
) (
  input logic                  clk,
  input logic                  rst,
  ld_st_wakeup_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]     head, tail;
  logic [DEPTH-1:0] valid;
  ld_st_data_pkt_t mem [DEPTH];
  ld_st_data_pkt_t woken [DEPTH];
  ld_st_data_pkt_t enq_woken;
  logic full, empty, push, pop;
  assign full = head[AW] != tail[AW] && head[AW-1:0] == tail[AW-1:0];
  assign empty = head == tail;
  assign bus.enq_ready = !full;
  assign bus.deq_pkt = mem[head[AW-1:0]];
  assign bus.deq_valid = !empty && bus.deq_pkt.ready;
  assign bus.count = tail - head;
  assign push = bus.enq_valid && !full;
  assign pop = bus.deq_valid && bus.deq_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    cdb_wakeup_match #(.NUM_CDB(NUM_CDB)) u_match (
      .entry_in  (mem[i]),
      .cdb       (bus.cdb_pkt),
      .entry_out (woken[i])
    );
  end
  cdb_wakeup_match #(.NUM_CDB(NUM_CDB)) u_enq_match (
    .entry_in  (bus.enq_pkt),
    .cdb       (bus.cdb_pkt),
    .entry_out (enq_woken)
  );
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      head <= '0;
      tail <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail[AW-1:0]] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (pop) begin
        valid[head[AW-1:0]] <= 1'b0;
        head <= head + 1'b1;
      end
    end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) mem[i] <= woken[i];
    if (push) mem[tail[AW-1:0]] <= enq_woken;
  end
endmodule
